umstr_tdp_ram_be: RTL and testbench

- Single-clock true dual-port RAM with per-byte write enables and selectable read-during-write mode.
- Optional output pipeline register and per-port read-valid strobes.
- Deterministic cross-port collision resolution with a collision flag.
- Serves as the generic packet/header buffer primitive for UDP master datapaths where both ports run in one clock domain.

---
 rtl/umstr_tdp_ram_be.sv | 182 ++++++++++++++++++
 tb/tb_umstr_tdp_ram_be.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umstr_tdp_ram_be.sv
// Single-clock true dual-port RAM with per-byte write enables and per-port valid strobes.
// Same-address conflicts are resolved per lane by a fixed priority and flagged on collision.
module umstr_tdp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int WR_PRIO    = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            data_a,
    output logic [DATA_WIDTH-1:0]            q_a,
    output logic                             valid_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            data_b,
    output logic [DATA_WIDTH-1:0]            q_b,
    output logic                             valid_b,
    output logic                             collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (((DATA_WIDTH % BYTE_WIDTH) != 0) || (RDW_MODE > 2) || (RDW_MODE < 0)) begin : g_param_err
        $error("umstr_tdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and RDW_MODE must be 0..2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NB-1:0]         lane_a;
    logic [NB-1:0]         lane_b;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] old_a;
    logic [DATA_WIDTH-1:0] old_b;
    logic [DATA_WIDTH-1:0] merged_a;
    logic [DATA_WIDTH-1:0] merged_b;
    logic                  coll_nxt;

    logic [DATA_WIDTH-1:0] q1_a;
    logic [DATA_WIDTH-1:0] q1_b;
    logic                  v1_a;
    logic                  v1_b;
    logic                  coll1;
    logic [DATA_WIDTH-1:0] q1_a_nxt;
    logic [DATA_WIDTH-1:0] q1_b_nxt;
    logic                  v1_a_nxt;
    logic                  v1_b_nxt;

    assign lane_a    = {NB{en_a}} & we_a;
    assign lane_b    = {NB{en_b}} & we_b;
    assign same_addr = (addr_a == addr_b);
    assign old_a     = mem[addr_a];
    assign old_b     = mem[addr_b];
    assign coll_nxt  = en_a & en_b & same_addr & ((|lane_a) | (|lane_b));

    // Write-first view of each port's own lanes, i.e. the lane value memory holds after this edge.
    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (lane_a[i]) begin
                if (same_addr && lane_b[i] && (WR_PRIO == 1))
                    merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                else
                    merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (lane_b[i]) begin
                if (same_addr && lane_a[i] && (WR_PRIO == 0))
                    merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                else
                    merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // The priority port is written last so its lane wins on a same-address overlap.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (WR_PRIO == 0) begin
                if (lane_b[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (lane_a[i]) mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                if (lane_a[i]) mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (lane_b[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        q1_a_nxt = q1_a;
        v1_a_nxt = 1'b0;
        if (en_a) begin
            if (lane_a == '0) begin
                q1_a_nxt = old_a;
                v1_a_nxt = 1'b1;
            end else if (RDW_MODE == 0) begin
                q1_a_nxt = merged_a;
                v1_a_nxt = 1'b1;
            end else if (RDW_MODE == 1) begin
                q1_a_nxt = old_a;
                v1_a_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        q1_b_nxt = q1_b;
        v1_b_nxt = 1'b0;
        if (en_b) begin
            if (lane_b == '0) begin
                q1_b_nxt = old_b;
                v1_b_nxt = 1'b1;
            end else if (RDW_MODE == 0) begin
                q1_b_nxt = merged_b;
                v1_b_nxt = 1'b1;
            end else if (RDW_MODE == 1) begin
                q1_b_nxt = old_b;
                v1_b_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1_a  <= '0;
            q1_b  <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
            coll1 <= 1'b0;
        end else begin
            q1_a  <= q1_a_nxt;
            q1_b  <= q1_b_nxt;
            v1_a  <= v1_a_nxt;
            v1_b  <= v1_b_nxt;
            coll1 <= coll_nxt;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q2_a;
        logic [DATA_WIDTH-1:0] q2_b;
        logic                  v2_a;
        logic                  v2_b;
        logic                  coll2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q2_a  <= '0;
                q2_b  <= '0;
                v2_a  <= 1'b0;
                v2_b  <= 1'b0;
                coll2 <= 1'b0;
            end else begin
                q2_a  <= q1_a;
                q2_b  <= q1_b;
                v2_a  <= v1_a;
                v2_b  <= v1_b;
                coll2 <= coll1;
            end
        end

        assign q_a       = q2_a;
        assign q_b       = q2_b;
        assign valid_a   = v2_a;
        assign valid_b   = v2_b;
        assign collision = coll2;
    end else begin : g_no_out_reg
        assign q_a       = q1_a;
        assign q_b       = q1_b;
        assign valid_a   = v1_a;
        assign valid_b   = v1_b;
        assign collision = coll1;
    end

endmodule

// File: tb/tb_umstr_tdp_ram_be.sv
// Directed bench: three parameterisations share one stimulus stream and are checked against hand-computed values.
module tb_umstr_tdp_ram_be;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [3:0]  we_a = '0;
    logic [3:0]  we_b = '0;
    logic [7:0]  addr_a = '0;
    logic [7:0]  addr_b = '0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;

    logic [31:0] q_a [3];
    logic [31:0] q_b [3];
    logic        valid_a [3];
    logic        valid_b [3];
    logic        collision [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: write-first, latency 1, A priority
    umstr_tdp_ram_be #(.RDW_MODE(0), .OUT_REG(0), .WR_PRIO(0)) d0 (
        .clk(clk), .reset_n(reset_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[0]), .valid_a(valid_a[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[0]), .valid_b(valid_b[0]),
        .collision(collision[0]));

    // d1: read-first, latency 2, B priority
    umstr_tdp_ram_be #(.RDW_MODE(1), .OUT_REG(1), .WR_PRIO(1)) d1 (
        .clk(clk), .reset_n(reset_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[1]), .valid_a(valid_a[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[1]), .valid_b(valid_b[1]),
        .collision(collision[1]));

    // d2: no-change, latency 1, A priority
    umstr_tdp_ram_be #(.RDW_MODE(2), .OUT_REG(0), .WR_PRIO(0)) d2 (
        .clk(clk), .reset_n(reset_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[2]), .valid_a(valid_a[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[2]), .valid_b(valid_b[2]),
        .collision(collision[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = '0;
        en_b = 1'b0; we_b = '0;
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        en_a = 1'b1; we_a = we; addr_a = a; data_a = d;
    endtask

    task automatic rd_a(input logic [7:0] a);
        en_a = 1'b1; we_a = '0; addr_a = a;
    endtask

    task automatic wr_b(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        en_b = 1'b1; we_b = we; addr_b = a; data_b = d;
    endtask

    task automatic rd_b(input logic [7:0] a);
        en_b = 1'b1; we_b = '0; addr_b = a;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({q_a[k], q_b[k], valid_a[k], valid_b[k], collision[k]} !== 67'd0) begin
                errors++;
                $display("FAIL reset_state d%0d: q_a=%h q_b=%h va=%b vb=%b col=%b, required all zero",
                         k, q_a[k], q_b[k], valid_a[k], valid_b[k], collision[k]);
            end
        end
    endtask

    task automatic test_byte_merge();
        idle();
        wr_a(8'd5, 32'h11223344, 4'hF);
        tick();
        wr_a(8'd5, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        rd_b(8'd5);
        tick();
        idle();
        checks++;
        if ({q_b[0], valid_b[0]} !== {32'h11BB33DD, 1'b1}) begin
            errors++;
            $display("FAIL merge_d0: q_b=%h vb=%b, required 11bb33dd/1", q_b[0], valid_b[0]);
        end
        checks++;
        if ({q_b[2], valid_b[2]} !== {32'h11BB33DD, 1'b1}) begin
            errors++;
            $display("FAIL merge_d2: q_b=%h vb=%b, required 11bb33dd/1", q_b[2], valid_b[2]);
        end
        checks++;
        if (valid_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL merge_d1_early: vb=%b, required 0", valid_b[1]);
        end
        tick();
        checks++;
        if ({q_b[1], valid_b[1]} !== {32'h11BB33DD, 1'b1}) begin
            errors++;
            $display("FAIL merge_d1_lat2: q_b=%h vb=%b, required 11bb33dd/1", q_b[1], valid_b[1]);
        end
        checks++;
        if (valid_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL merge_d0_oneshot: vb=%b, required 0", valid_b[0]);
        end
    endtask

    task automatic test_rdw();
        idle();
        rd_a(8'd5);
        tick();
        wr_a(8'd7, 32'h0, 4'hF);
        tick();
        wr_a(8'd7, 32'hCAFEBABE, 4'hF);
        tick();
        idle();
        checks++;
        if ({q_a[0], valid_a[0]} !== {32'hCAFEBABE, 1'b1}) begin
            errors++;
            $display("FAIL rdw_write_first: q_a=%h va=%b, required cafebabe/1", q_a[0], valid_a[0]);
        end
        checks++;
        if ({q_a[2], valid_a[2]} !== {32'h11BB33DD, 1'b0}) begin
            errors++;
            $display("FAIL rdw_no_change: q_a=%h va=%b, required 11bb33dd/0", q_a[2], valid_a[2]);
        end
        tick();
        checks++;
        if ({q_a[1], valid_a[1]} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL rdw_read_first: q_a=%h va=%b, required 00000000/1", q_a[1], valid_a[1]);
        end
    endtask

    task automatic test_collision();
        idle();
        wr_a(8'd9, 32'h12345678, 4'hF);
        tick();
        wr_a(8'd9, 32'hFFFFFFFF, 4'hF);
        rd_b(8'd9);
        tick();
        idle();
        checks++;
        if ({q_b[0], valid_b[0], collision[0], q_a[0]} !== {32'h12345678, 1'b1, 1'b1, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL coll_d0: q_b=%h vb=%b col=%b q_a=%h, required 12345678/1/1/ffffffff",
                     q_b[0], valid_b[0], collision[0], q_a[0]);
        end
        checks++;
        if ({q_b[2], collision[2], valid_a[2]} !== {32'h12345678, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL coll_d2: q_b=%h col=%b va=%b, required 12345678/1/0", q_b[2], collision[2], valid_a[2]);
        end
        rd_b(8'd9);
        tick();
        idle();
        checks++;
        if ({q_b[0], collision[0]} !== {32'hFFFFFFFF, 1'b0}) begin
            errors++;
            $display("FAIL coll_after_d0: q_b=%h col=%b, required ffffffff/0", q_b[0], collision[0]);
        end
        checks++;
        if ({q_b[1], valid_b[1], collision[1]} !== {32'h12345678, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL coll_d1_lat2: q_b=%h vb=%b col=%b, required 12345678/1/1", q_b[1], valid_b[1], collision[1]);
        end
        rd_a(8'd9);
        rd_b(8'd9);
        tick();
        idle();
        checks++;
        if ({q_a[0], q_b[0], collision[0]} !== {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0}) begin
            errors++;
            $display("FAIL dual_read_d0: q_a=%h q_b=%h col=%b, required ffffffff/ffffffff/0", q_a[0], q_b[0], collision[0]);
        end
        checks++;
        if ({q_b[1], collision[1]} !== {32'hFFFFFFFF, 1'b0}) begin
            errors++;
            $display("FAIL coll_after_d1: q_b=%h col=%b, required ffffffff/0", q_b[1], collision[1]);
        end
        tick();
        checks++;
        if (collision[1] !== 1'b0) begin
            errors++;
            $display("FAIL dual_read_d1: col=%b, required 0", collision[1]);
        end
    endtask

    task automatic test_dual_write();
        idle();
        wr_a(8'd3, 32'h0, 4'hF);
        tick();
        wr_a(8'd3, 32'h000000AA, 4'b0001);
        wr_b(8'd3, 32'hBBBBBBBB, 4'b0011);
        tick();
        idle();
        checks++;
        if ({collision[0], collision[2], q_b[0], valid_b[0]} !== {1'b1, 1'b1, 32'h0000BBAA, 1'b1}) begin
            errors++;
            $display("FAIL dual_wr_stage1: col0=%b col2=%b q_b0=%h vb0=%b, required 1/1/0000bbaa/1",
                     collision[0], collision[2], q_b[0], valid_b[0]);
        end
        rd_a(8'd3);
        tick();
        idle();
        checks++;
        if ({q_a[0], q_a[2]} !== {32'h0000BBAA, 32'h0000BBAA}) begin
            errors++;
            $display("FAIL dual_wr_prio_a: q_a0=%h q_a2=%h, required 0000bbaa", q_a[0], q_a[2]);
        end
        checks++;
        if ({collision[1], q_b[1], valid_b[1]} !== {1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL dual_wr_d1_lat2: col=%b q_b=%h vb=%b, required 1/00000000/1", collision[1], q_b[1], valid_b[1]);
        end
        tick();
        checks++;
        if ({q_a[1], valid_a[1], collision[1]} !== {32'h0000BBBB, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dual_wr_prio_b: q_a=%h va=%b col=%b, required 0000bbbb/1/0", q_a[1], valid_a[1], collision[1]);
        end
    endtask

    task automatic test_back_to_back();
        int consec;
        consec = 0;
        for (int i = 0; i < 16; i++) begin
            wr_a(8'(i), 32'hC0DE0000 + 32'(i), 4'hF);
            tick();
        end
        idle();
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) rd_a(8'(k));
            else idle();
            tick();
            if (k < 16) begin
                checks++;
                if ({q_a[0], valid_a[0]} !== {32'hC0DE0000 + 32'(k), 1'b1}) begin
                    errors++;
                    $display("FAIL stream_d0[%0d]: q_a=%h va=%b, required %h/1", k, q_a[0], valid_a[0], 32'hC0DE0000 + 32'(k));
                end
            end
            if (k >= 1) begin
                checks++;
                if ({q_a[1], valid_a[1]} !== {32'hC0DE0000 + 32'(k - 1), 1'b1}) begin
                    errors++;
                    $display("FAIL stream_d1[%0d]: q_a=%h va=%b, required %h/1", k - 1, q_a[1], valid_a[1], 32'hC0DE0000 + 32'(k - 1));
                end
                if (valid_a[1] === 1'b1) consec++;
            end
        end
        checks++;
        if (consec != 16) begin
            errors++;
            $display("FAIL stream_count: valid run=%0d, required 16", consec);
        end
        tick();
        checks++;
        if (valid_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL stream_tail: va=%b, required 0", valid_a[1]);
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 4; k++) begin
            rd_a(8'(k));
            tick();
        end
        idle();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({valid_a[0], valid_a[1], q_a[1]} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midreset_immediate: va0=%b va1=%b q_a1=%h, required 0/0/00000000", valid_a[0], valid_a[1], q_a[1]);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({valid_a[0], valid_a[1]} !== 2'b00) begin
                errors++;
                $display("FAIL midreset_after[%0d]: va0=%b va1=%b, required 0/0", k, valid_a[0], valid_a[1]);
            end
        end
        rd_a(8'd2);
        tick();
        idle();
        checks++;
        if (valid_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_new_early: va1=%b, required 0", valid_a[1]);
        end
        tick();
        checks++;
        if ({q_a[1], valid_a[1]} !== {32'hC0DE0002, 1'b1}) begin
            errors++;
            $display("FAIL midreset_new_read: q_a=%h va=%b, required c0de0002/1", q_a[1], valid_a[1]);
        end
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_rdw();
        test_collision();
        test_dual_write();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
